// File: rtl/seq_mult_sm.sv
// Sequential shift-and-add multiplier. Signed or unsigned mode, 2*DW-bit product,
// one add-and-shift per cycle (DW-cycle latency) behind a ready/start/done handshake.
module seq_mult_sm #(
  parameter int DW = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_signed,
  input  logic [DW-1:0]   i_multd_val,
  input  logic [DW-1:0]   i_multr_val,
  output logic            o_ready,
  output logic            o_busy,
  output logic            o_done,
  output logic [2*DW-1:0] o_product
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0]   a_reg;
  logic [DW-1:0]   q_reg;
  logic [DW:0]     acc_reg;
  logic            neg_reg;
  logic [CW-1:0]   cnt_reg;

  logic            latch;
  logic            last_step;
  logic [DW-1:0]   multd_mag;
  logic [DW-1:0]   multr_mag;
  logic [DW:0]     sum;
  logic [2*DW-1:0] raw_product;
  logic [2*DW-1:0] final_product;

  assign last_step = (cnt_reg == CW'(1));

  // The most negative value maps onto 2^(DW-1), which is exact as an unsigned magnitude.
  assign multd_mag = (i_signed && i_multd_val[DW-1]) ? (~i_multd_val + DW'(1)) : i_multd_val;
  assign multr_mag = (i_signed && i_multr_val[DW-1]) ? (~i_multr_val + DW'(1)) : i_multr_val;

  assign sum           = acc_reg + (q_reg[0] ? {1'b0, a_reg} : '0);
  assign raw_product   = {sum, q_reg[DW-1:1]};
  assign final_product = neg_reg ? (~raw_product + (2*DW)'(1)) : raw_product;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt = CALC;
          latch     = 1'b1;
        end
      end
      CALC: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        if (i_start) begin
          state_nxt = CALC;
          latch     = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      a_reg     <= '0;
      q_reg     <= '0;
      acc_reg   <= '0;
      neg_reg   <= 1'b0;
      cnt_reg   <= '0;
      o_product <= '0;
    end else if (latch) begin
      a_reg   <= multd_mag;
      q_reg   <= multr_mag;
      acc_reg <= '0;
      neg_reg <= i_signed & (i_multd_val[DW-1] ^ i_multr_val[DW-1]);
      cnt_reg <= CW'(DW);
    end else if (state == CALC) begin
      // Add and shift fused: {ACC,Q} <= {sum,Q} >> 1.
      acc_reg <= {1'b0, sum[DW:1]};
      q_reg   <= {sum[0], q_reg[DW-1:1]};
      cnt_reg <= cnt_reg - CW'(1);
      if (last_step) o_product <= final_product;
    end
  end

  assign o_ready = (state == IDLE) || (state == DONE);
  assign o_busy  = (state == CALC);
  assign o_done  = (state == DONE);

endmodule

// File: tb/tb_seq_mult_sm.sv
// Directed bench for seq_mult_sm: DW=8 and DW=16 instances, hand-computed products,
// latency, back-to-back handshake, ignored mid-operation start and asynchronous reset.
module tb_seq_mult_sm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sgn = 1'b0;
  logic        start8 = 1'b0;
  logic        start16 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ready8, busy8, done8;
  logic        ready16, busy16, done16;
  logic [15:0] prod8;
  logic [31:0] prod16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_mult_sm #(.DW(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst_n), .i_start(start8), .i_signed(sgn),
    .i_multd_val(a8), .i_multr_val(b8),
    .o_ready(ready8), .o_busy(busy8), .o_done(done8), .o_product(prod8)
  );

  seq_mult_sm #(.DW(16)) u_dut16 (
    .i_clk(clk), .i_rst(rst_n), .i_start(start16), .i_signed(sgn),
    .i_multd_val(a16), .i_multr_val(b16),
    .o_ready(ready16), .o_busy(busy16), .o_done(done16), .o_product(prod16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done8 at successive falling edges; cycles counts the edges waited.
  task automatic wait_done8(output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cycles++;
      if (done8) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_op(input bit w16, input bit s, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input string tag);
    int busy_cnt;
    bit seen;
    @(negedge clk);
    sgn = s;
    if (w16) begin
      a16 = a; b16 = b; start16 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
    end
    @(negedge clk);
    start8 = 1'b0;
    start16 = 1'b0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (w16 ? done16 : done8) seen = 1'b1;
      else begin
        if (w16 ? busy16 : busy8) busy_cnt++;
        @(negedge clk);
      end
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), w16 ? 32'd16 : 32'd8);
    check({tag, "_product"}, w16 ? prod16 : {16'h0, prod8}, exp);
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(w16 ? done16 : done8), 32'd0);
  endtask

  initial begin
    int cyc;
    int extra;
    bit ok;

    #1;
    check("rst_ready", 32'(ready8), 32'd1);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_product", {16'h0, prod8}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01, "u_255x255");
    run_op(1'b0, 1'b1, 16'h00FD, 16'h0005, 32'h0000FFF1, "s_m3x5");
    run_op(1'b0, 1'b0, 16'h00FD, 16'h0005, 32'h000004F1, "u_253x5");
    run_op(1'b0, 1'b1, 16'h0080, 16'h0080, 32'h00004000, "s_m128xm128");
    run_op(1'b0, 1'b1, 16'h0080, 16'h0001, 32'h0000FF80, "s_m128x1");
    run_op(1'b0, 1'b1, 16'h0000, 16'h0085, 32'h00000000, "s_zero");

    // Start pulse with new operands in the middle of CALC must be ignored.
    @(negedge clk);
    sgn = 1'b0; a8 = 8'd10; b8 = 8'd10; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd200; sgn = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(cyc, ok);
    check("ign_done", 32'(ok), 32'd1);
    check("ign_product", {16'h0, prod8}, 32'h00000064);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) extra++;
    end
    check("ign_single_pulse", 32'(extra), 32'd0);

    // Start held high: back-to-back operations DW+1 cycles apart.
    @(negedge clk);
    sgn = 1'b0; a8 = 8'd3; b8 = 8'd4; start8 = 1'b1;
    wait_done8(cyc, ok);
    check("b2b_first_done", 32'(ok), 32'd1);
    check("b2b_first_product", {16'h0, prod8}, 32'h0000000C);
    check("b2b_first_ready", 32'(ready8), 32'd1);
    a8 = 8'd7; b8 = 8'd9;
    wait_done8(cyc, ok);
    check("b2b_second_done", 32'(ok), 32'd1);
    check("b2b_gap", 32'(cyc), 32'd9);
    check("b2b_second_product", {16'h0, prod8}, 32'h0000003F);
    check("b2b_second_ready", 32'(ready8), 32'd1);
    start8 = 1'b0;
    @(negedge clk);
    check("b2b_idle_after", 32'(done8), 32'd0);

    // Asynchronous reset four cycles into CALC abandons the operation.
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd5; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(ready8), 32'd1);
    check("arst_busy", 32'(busy8), 32'd0);
    check("arst_done", 32'(done8), 32'd0);
    check("arst_product", {16'h0, prod8}, 32'h0);
    extra = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) extra++;
    end
    check("arst_no_done", 32'(extra), 32'd0);
    run_op(1'b0, 1'b0, 16'h0006, 16'h0007, 32'h0000002A, "post_rst_6x7");

    run_op(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "w16_u_max");
    run_op(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, "w16_s_m1xm1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_sm.md
Name: seq_mult_sm

Overview:
- Parametrised sequential shift-and-add multiplier. Successor to the fixed 8-bit multiplier datapath with separate control.
- Adds a per-operation signed/unsigned mode, a 2*DW-bit product and a single-cycle add+shift step (fixed latency DW).
- Adds a ready/start/done handshake that allows back-to-back operations.
- Sits beside the existing arithmetic blocks as a drop-in multiply unit for controllers that issue one product at a time.

Parameters:
- DW, 8, operand width in bits (legal DW >= 2). The product is 2*DW bits.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-low.
- i_start  in  1  request; sampled on the rising edge when o_ready=1.
- i_signed  in  1  1 = two's-complement operands, 0 = unsigned; latched with i_start.
- i_multd_val  in  DW  multiplicand; latched with i_start.
- i_multr_val  in  DW  multiplier; latched with i_start.
- o_ready  out  1  block can accept i_start (state IDLE or DONE).
- o_busy  out  1  computation in progress (state CALC).
- o_done  out  1  one-cycle pulse: o_product is updated and valid.
- o_product  out  2*DW  result; holds its value until the next completion.

Behaviour:
- Reset (i_rst=0, asynchronous): state goes to IDLE and all registers clear to 0.
  - Reset values: o_ready=1, o_busy=0, o_done=0, o_product=0.
  - Reset in the middle of an operation abandons it. No o_done is produced.
- States: IDLE, CALC, DONE.
  - IDLE: o_ready=1. On i_start=1, go to CALC and latch the operands, the mode and the sign information (described below). Otherwise stay in IDLE.
  - CALC: o_busy=1, o_ready=0. Runs exactly DW cycles, counted by a step counter (width clog2(DW+1)) loaded with DW that decrements each cycle. On the step where the counter is 1, go to DONE. i_start is ignored in this state.
  - DONE: o_done=1 for exactly this one cycle, o_ready=1. On i_start=1, go to CALC with a new latch (back-to-back operation, no idle gap). Otherwise go to IDLE.
- Operand latch:
  - In signed mode, take the magnitude of each operand.
    - |x| = ~x+1 when x[DW-1]=1, computed in DW bits.
    - -2^(DW-1) maps to 2^(DW-1) as an unsigned value, which is exact.
  - Store neg = multd[DW-1] XOR multr[DW-1].
  - In unsigned mode, the operands are used unchanged and neg=0.
- Datapath:
  - Registers: A (multiplicand magnitude, DW bits) and accumulator {ACC (DW+1 bits), Q (DW bits)}. Q holds the multiplier magnitude; ACC is cleared on latch.
  - Each CALC cycle: sum = ACC + (Q[0] ? A : 0), computed as DW+1 bits with the carry kept. Then {ACC,Q} <= {sum,Q} >> 1, a logical shift.
  - The single add-and-shift per cycle is mandatory; there is no separate add state.
- Completion:
  - On the final CALC edge, compute the raw product P = {sum,Q} >> 1, taking the low 2*DW bits.
  - o_product <= neg ? (~P+1) : P, computed in 2*DW bits.
  - o_done is registered, so it rises together with the o_product update.
- Latency: if i_start is sampled at edge k, o_done=1 and the new o_product are visible after edge k+DW. The next start can be sampled at edge k+DW+1.
- Edge cases:
  - A zero operand yields 0 in either mode; neg does not create -0.
  - Operand or mode changes during CALC have no effect.
  - i_start held high continuously produces back-to-back operations every DW+1 cycles.

Test Plan:
- DW=8, unsigned, 255*255, start at edge k -> o_done pulse after edge k+8, o_product=16'hFE01, o_busy=1 for 8 cycles.
- DW=8, signed, 8'hFD*8'h05 (-3*5) -> 16'hFFF1. The same operands unsigned (253*5) -> 16'h04F1.
- DW=8, signed, 8'h80*8'h80 (-128*-128) -> 16'h4000. Also 8'h80*8'h01 -> 16'hFF80.
- Pulse i_start during CALC with different operands -> ignored. The first result is unchanged, and only one o_done pulse occurs.
- i_start held high with operands 3*4 then 7*9 -> o_done pulses 9 cycles apart with 16'h000C then 16'h003F. o_ready=1 in each DONE cycle.
- Assert i_rst=0 asynchronously, mid-clock, 4 cycles into CALC -> outputs reset immediately with no o_done pulse. After release, 6*7 gives 16'h002A.
- DW=16, unsigned 16'hFFFF*16'hFFFF -> 32'hFFFE0001 with 16-cycle latency. Signed 16'hFFFF*16'hFFFF -> 32'h00000001.
